// File: rtl/display_scanner.sv
// Time-multiplexed scanner for a 4-digit common-anode seven-segment display.
// Optional leading-zero blanking is enabled with `define SCAN_BLANK_LEADING_ZEROS_EN.
module display_scanner #(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    output logic [3:0]  digit,
    output logic [3:0]  anode,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_C   = CW'(GAP_CYCLES);

    typedef enum logic {
        GAP,
        ON
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [1:0]    idx;
    logic          slot_end;
    logic          boundary;
    logic          gap_next;
    logic [15:0]   shadow;
    logic          pending;
    logic [15:0]   disp;
    logic [3:0]    blank;

    always_comb begin
        slot_end = (cnt == CNT_MAX);
        boundary = slot_end && (idx == 2'd3);
        cnt_next = slot_end ? '0 : cnt + 1'b1;
    end

    // With no dead time the comparison would be constant, so it is elided.
    generate
        if (GAP_CYCLES == 0) begin : g_no_gap
            assign gap_next = 1'b0;
        end else begin : g_gap
            assign gap_next = (cnt_next < GAP_C);
        end
    endgenerate

    always_comb begin
        state_next = ON;
        if (gap_next) begin
            state_next = GAP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= GAP;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else begin
            cnt <= cnt_next;
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // A load on the boundary bypasses the shadow so it shows in the next slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= 16'h0000;
            pending <= 1'b0;
            disp    <= 16'h0000;
        end else begin
            if (load) begin
                shadow <= value;
            end
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    disp <= value;
                end else if (pending) begin
                    disp <= shadow;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        blank = 4'b0000;
`ifdef SCAN_BLANK_LEADING_ZEROS_EN
        blank[3] = (disp[15:12] == 4'h0);
        blank[2] = (disp[15:8] == 8'h00);
        blank[1] = (disp[15:4] == 12'h000);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit      <= 4'h0;
            anode      <= 4'b1111;
            frame_done <= 1'b0;
        end else begin
            digit      <= disp[{idx, 2'b00} +: 4];
            frame_done <= boundary;
            if ((state == GAP) || blank[idx]) begin
                anode <= 4'b1111;
            end else begin
                anode <= ~(4'b0001 << idx);
            end
        end
    end

endmodule
